// File: rtl/fml_vtx_trace_capture_pkg.sv
// Shared definitions for the vertex trace capture block: default sizes and FSM encoding.
package fml_vtx_trace_capture_pkg;
  localparam int NTXN_DEF = 4;
  localparam int NCPR_DEF = 16;
  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_COMMIT = 2'd2
  } vtx_state_e;
endpackage

// File: rtl/fml_vtx_mem_log.sv
// NTXN-slot memory transaction recorder: clear on issue, push per completed txn, saturate and flag overflow.
module fml_vtx_mem_log #(
  parameter int NTXN = 4,
  parameter int XLEN = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic                       i_wen,
  input  logic                       i_error,
  input  logic [XLEN-1:0]            i_addr,
  input  logic [XLEN-1:0]            i_wdata,
  input  logic [XLEN-1:0]            i_rdata,
  input  logic [3:0]                 i_ben,
  output logic [NTXN-1:0]            o_cen,
  output logic [NTXN-1:0]            o_wen,
  output logic [NTXN-1:0]            o_error,
  output logic [NTXN-1:0][XLEN-1:0]  o_addr,
  output logic [NTXN-1:0][XLEN-1:0]  o_wdata,
  output logic [NTXN-1:0][XLEN-1:0]  o_rdata,
  output logic [NTXN-1:0][3:0]       o_ben,
  output logic                       o_ovf
);
  localparam int CW = $clog2(NTXN + 1);

  logic [CW-1:0]              r_cnt;
  logic                       r_ovf;
  logic [NTXN-1:0]            r_cen, r_wen, r_err;
  logic [NTXN-1:0][XLEN-1:0]  r_addr, r_wdata, r_rdata;
  logic [NTXN-1:0][3:0]       r_ben;
  logic                       w_full;

  assign w_full = (r_cnt == CW'(NTXN));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || i_clear) begin
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_cen   <= '0;
      r_wen   <= '0;
      r_err   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ben   <= '0;
    end else if (i_push) begin
      if (w_full) begin
        r_ovf <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
        for (int s = 0; s < NTXN; s++) begin
          if (r_cnt == CW'(s)) begin
            r_cen[s]   <= 1'b1;
            r_wen[s]   <= i_wen;
            r_err[s]   <= i_error;
            r_addr[s]  <= i_addr;
            r_wdata[s] <= i_wdata;
            r_rdata[s] <= i_rdata;
            r_ben[s]   <= i_ben;
          end
        end
      end
    end
  end

  assign o_cen   = r_cen;
  assign o_wen   = r_wen;
  assign o_error = r_err;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_rdata = r_rdata;
  assign o_ben   = r_ben;
  assign o_ovf   = r_ovf;
endmodule

// File: rtl/fml_vtx_trace_capture.sv
// Passive retire-trace monitor: snapshots CPRs around each instruction plus its memory txns, emits one record strobe.
module fml_vtx_trace_capture
  import fml_vtx_trace_capture_pkg::*;
#(
  parameter int NTXN = NTXN_DEF,
  parameter int NCPR = NCPR_DEF,
  parameter int XLEN = XLEN_DEF
) (
  input  logic                       i_vtx_clk,
  input  logic                       i_vtx_reset,
  input  logic                       i_cop_insn_valid,
  input  logic                       i_cop_insn_ready,
  input  logic [XLEN-1:0]            i_cop_insn_enc,
  input  logic [XLEN-1:0]            i_cop_insn_rs1,
  input  logic                       i_cop_rsp_valid,
  input  logic                       i_cop_rsp_ready,
  input  logic [2:0]                 i_cop_rsp_result,
  input  logic                       i_cop_rsp_wen,
  input  logic [4:0]                 i_cop_rsp_waddr,
  input  logic [XLEN-1:0]            i_cop_rsp_wdata,
  input  logic [NCPR-1:0][XLEN-1:0]  i_cop_cprs,
  input  logic                       i_mem_cen,
  input  logic                       i_mem_wen,
  input  logic                       i_mem_stall,
  input  logic [XLEN-1:0]            i_mem_addr,
  input  logic [XLEN-1:0]            i_mem_wdata,
  input  logic [XLEN-1:0]            i_mem_rdata,
  input  logic [3:0]                 i_mem_ben,
  input  logic                       i_mem_error,
  output logic                       o_vtx_valid,
  output logic [XLEN-1:0]            o_vtx_instr_enc,
  output logic [XLEN-1:0]            o_vtx_instr_rs1,
  output logic [2:0]                 o_vtx_instr_result,
  output logic [XLEN-1:0]            o_vtx_instr_wdata,
  output logic [4:0]                 o_vtx_instr_waddr,
  output logic                       o_vtx_instr_wen,
  output logic [NCPR-1:0][XLEN-1:0]  o_vtx_cprs_pre,
  output logic [NCPR-1:0][XLEN-1:0]  o_vtx_cprs_post,
  output logic [NTXN-1:0]            o_vtx_mem_cen,
  output logic [NTXN-1:0]            o_vtx_mem_wen,
  output logic [NTXN-1:0]            o_vtx_mem_error,
  output logic [NTXN-1:0][XLEN-1:0]  o_vtx_mem_addr,
  output logic [NTXN-1:0][XLEN-1:0]  o_vtx_mem_wdata,
  output logic [NTXN-1:0][XLEN-1:0]  o_vtx_mem_rdata,
  output logic [NTXN-1:0][3:0]       o_vtx_mem_ben,
  output logic                       o_vtx_mem_ovf,
  output logic                       o_vtx_proto_err
);
  vtx_state_e r_state, w_next;
  logic w_issue, w_rsp, w_txn, w_latch_issue, w_latch_rsp, w_push, w_err;

  // In-flight capture; copied into the published record on the COMMIT edge so an
  // overlapping issue never disturbs the record being strobed.
  logic [XLEN-1:0]           r_cur_enc, r_cur_rs1, r_cur_wdata;
  logic [2:0]                r_cur_result;
  logic [4:0]                r_cur_waddr;
  logic                      r_cur_wen;
  logic [NCPR-1:0][XLEN-1:0] r_cur_pre;

  logic [NTXN-1:0]           w_log_cen, w_log_wen, w_log_err;
  logic [NTXN-1:0][XLEN-1:0] w_log_addr, w_log_wdata, w_log_rdata;
  logic [NTXN-1:0][3:0]      w_log_ben;
  logic                      w_log_ovf;

  assign w_issue = i_cop_insn_valid & i_cop_insn_ready;
  assign w_rsp   = i_cop_rsp_valid & i_cop_rsp_ready;
  assign w_txn   = i_mem_cen & ~i_mem_stall;

  always_comb begin
    w_next        = r_state;
    w_latch_issue = 1'b0;
    w_latch_rsp   = 1'b0;
    w_push        = 1'b0;
    w_err         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_latch_issue = 1'b1;
          w_latch_rsp   = w_rsp;
          w_next        = w_rsp ? ST_COMMIT : ST_BUSY;
        end else if (w_rsp) begin
          w_err = 1'b1;
        end
        if (w_txn) w_err = 1'b1;
      end
      ST_BUSY: begin
        w_push = w_txn;
        if (w_issue) w_err = 1'b1;
        if (w_rsp) begin
          w_latch_rsp = 1'b1;
          w_next      = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (w_issue) begin
          w_latch_issue = 1'b1;
          w_latch_rsp   = w_rsp;
          w_next        = w_rsp ? ST_COMMIT : ST_BUSY;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_vtx_clk or posedge i_vtx_reset) begin
    if (i_vtx_reset) r_state <= ST_IDLE;
    else             r_state <= w_next;
  end

  fml_vtx_mem_log #(.NTXN(NTXN), .XLEN(XLEN)) u_mem_log (
    .i_clk   (i_vtx_clk),
    .i_rst   (i_vtx_reset),
    .i_clear (w_latch_issue),
    .i_push  (w_push),
    .i_wen   (i_mem_wen),
    .i_error (i_mem_error),
    .i_addr  (i_mem_addr),
    .i_wdata (i_mem_wdata),
    .i_rdata (i_mem_rdata),
    .i_ben   (i_mem_ben),
    .o_cen   (w_log_cen),
    .o_wen   (w_log_wen),
    .o_error (w_log_err),
    .o_addr  (w_log_addr),
    .o_wdata (w_log_wdata),
    .o_rdata (w_log_rdata),
    .o_ben   (w_log_ben),
    .o_ovf   (w_log_ovf)
  );

  always_ff @(posedge i_vtx_clk or posedge i_vtx_reset) begin
    if (i_vtx_reset) begin
      r_cur_enc          <= '0;
      r_cur_rs1          <= '0;
      r_cur_pre          <= '0;
      r_cur_result       <= '0;
      r_cur_wen          <= 1'b0;
      r_cur_waddr        <= '0;
      r_cur_wdata        <= '0;
      o_vtx_valid        <= 1'b0;
      o_vtx_instr_enc    <= '0;
      o_vtx_instr_rs1    <= '0;
      o_vtx_instr_result <= '0;
      o_vtx_instr_wdata  <= '0;
      o_vtx_instr_waddr  <= '0;
      o_vtx_instr_wen    <= 1'b0;
      o_vtx_cprs_pre     <= '0;
      o_vtx_cprs_post    <= '0;
      o_vtx_mem_cen      <= '0;
      o_vtx_mem_wen      <= '0;
      o_vtx_mem_error    <= '0;
      o_vtx_mem_addr     <= '0;
      o_vtx_mem_wdata    <= '0;
      o_vtx_mem_rdata    <= '0;
      o_vtx_mem_ben      <= '0;
      o_vtx_mem_ovf      <= 1'b0;
      o_vtx_proto_err    <= 1'b0;
    end else begin
      if (w_latch_issue) begin
        r_cur_enc <= i_cop_insn_enc;
        r_cur_rs1 <= i_cop_insn_rs1;
        r_cur_pre <= i_cop_cprs;
      end
      if (w_latch_rsp) begin
        r_cur_result <= i_cop_rsp_result;
        r_cur_wen    <= i_cop_rsp_wen;
        r_cur_waddr  <= i_cop_rsp_waddr;
        r_cur_wdata  <= i_cop_rsp_wdata;
      end
      if (w_err) o_vtx_proto_err <= 1'b1;
      o_vtx_valid <= (r_state == ST_COMMIT);
      // Coprocessor CPR writes from the response edge are visible by COMMIT.
      if (r_state == ST_COMMIT) begin
        o_vtx_instr_enc    <= r_cur_enc;
        o_vtx_instr_rs1    <= r_cur_rs1;
        o_vtx_instr_result <= r_cur_result;
        o_vtx_instr_wdata  <= r_cur_wdata;
        o_vtx_instr_waddr  <= r_cur_waddr;
        o_vtx_instr_wen    <= r_cur_wen;
        o_vtx_cprs_pre     <= r_cur_pre;
        o_vtx_cprs_post    <= i_cop_cprs;
        o_vtx_mem_cen      <= w_log_cen;
        o_vtx_mem_wen      <= w_log_wen;
        o_vtx_mem_error    <= w_log_err;
        o_vtx_mem_addr     <= w_log_addr;
        o_vtx_mem_wdata    <= w_log_wdata;
        o_vtx_mem_rdata    <= w_log_rdata;
        o_vtx_mem_ben      <= w_log_ben;
        o_vtx_mem_ovf      <= w_log_ovf;
      end
    end
  end
endmodule
